// File: rtl/mux_scan_ctrl.sv
// Select sequencer for a downstream 4:1 mux: walks {s1,s0} through 0..3,
// holding each value rate+1 cycles, and captures the mux output into capture[3:0].
module mux_scan_ctrl #(
  parameter int DIV_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] rate,
  input  logic                 m,
  output logic                 s0,
  output logic                 s1,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [3:0]           capture,
  output logic [1:0]           fsm_state
);

  // Handshake: start is level-sampled only in IDLE; busy is high for the
  // whole scan; done pulses for one cycle; valid qualifies capture until the
  // next accepted start or reset.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

  state_t               state, state_n;
  logic [1:0]           idx, idx_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] rate_q, rate_q_n;
  logic [3:0]           capture_n;
  logic                 valid_n;

  assign fsm_state = state;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    rate_q_n  = rate_q;
    capture_n = capture;
    valid_n   = valid;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = HOLD;
          rate_q_n  = rate;
          cnt_n     = rate;
          idx_n     = 2'd0;
          capture_n = 4'd0;
          valid_n   = 1'b0;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_ONE;
        end else begin
          // Last cycle of this hold: the mux has settled for the whole hold.
          capture_n[idx] = m;
          if (idx == 2'd3) begin
            state_n = DONE;
            valid_n = 1'b1;
          end else begin
            idx_n = idx + 2'd1;
            cnt_n = rate_q;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so they align with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 2'd0;
      cnt     <= '0;
      rate_q  <= '0;
      capture <= 4'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s0      <= 1'b0;
      s1      <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      rate_q  <= rate_q_n;
      capture <= capture_n;
      valid   <= valid_n;
      busy    <= (state_n == HOLD);
      done    <= (state_n == DONE);
      s0      <= (state_n == HOLD) ? idx_n[0] : 1'b0;
      s1      <= (state_n == HOLD) ? idx_n[1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 4:1 mux on m.
module tb_mux_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] rate;
  logic       m;
  logic       s0, s1, busy, done, valid;
  logic [3:0] capture;
  logic [1:0] fsm_state;
  logic [3:0] din;   // {x,w,v,u}
  logic [1:0] sel;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign sel = {s1, s0};
  assign m   = din[sel];

  mux_scan_ctrl #(.DIV_WIDTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .rate      (rate),
    .m         (m),
    .s0        (s0),
    .s1        (s1),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .capture   (capture),
    .fsm_state (fsm_state)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full scan from an idle DUT. r_mid is applied to rate right after the
  // start edge; noise keeps start asserted through HOLD and DONE.
  task automatic run_scan(input logic [3:0] data, input logic [3:0] r,
                          input logic [3:0] r_mid, input bit noise);
    logic [3:0] mk;
    din   = data;
    rate  = r;
    start = 1'b1;
    tick();
    start = noise;
    rate  = r_mid;
    for (int i = 0; i < 4; i++) begin
      mk = 4'((1 << i) - 1);
      for (int h = 0; h <= int'(r); h++) begin
        chk("scan_sel", 32'(sel), 32'(i));
        chk("scan_busy", 32'(busy), 32'd1);
        chk("scan_done", 32'(done), 32'd0);
        chk("scan_valid", 32'(valid), 32'd0);
        chk("scan_partial_capture", 32'(capture), 32'(data & mk));
        tick();
      end
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_valid", 32'(valid), 32'd1);
    chk("done_capture", 32'(capture), 32'(data));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_sel", 32'(sel), 32'd0);
    start = 1'b0;
    tick();
    chk("idle_done_low", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid_hold", 32'(valid), 32'd1);
    chk("idle_capture_hold", 32'(capture), 32'(data));
    tick();
    chk("idle_no_queued_start", 32'(busy), 32'd0);
    chk("idle_no_extra_done", 32'(done), 32'd0);
    chk("idle_valid_stay", 32'(valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rate  = 4'd0;
    din   = 4'b0000;
    tick();
    tick();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_capture", 32'(capture), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // u=1,v=0,w=1,x=1 at full rate, then at rate 3
    run_scan(4'b1101, 4'd0, 4'd0, 1'b0);
    run_scan(4'b1101, 4'd3, 4'd3, 1'b0);

    // u=0,v=1,w=1,x=0 at maximum hold; rate dropped to 0 mid-scan
    run_scan(4'b0110, 4'd15, 4'd0, 1'b0);

    // start re-pulsed during HOLD and DONE, then a fresh scan
    run_scan(4'b1001, 4'd1, 4'd1, 1'b1);
    run_scan(4'b0011, 4'd1, 4'd1, 1'b0);

    // Reset while idx=2 at rate 2
    din   = 4'b1011;
    rate  = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("pre_abort_sel", 32'(sel), 32'd2);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    chk("pre_abort_capture", 32'(capture), 32'b0011);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_capture", 32'(capture), 32'd0);
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    run_scan(4'b1011, 4'd2, 4'd2, 1'b0);

    // start held high at rate 0: a scan every 6 cycles
    din   = 4'b0101;
    rate  = 4'd0;
    start = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 4; k++) begin
        chk("b2b_sel", 32'(sel), 32'(k));
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_valid_low", 32'(valid), 32'd0);
        chk("b2b_done_low", 32'(done), 32'd0);
        tick();
      end
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_valid", 32'(valid), 32'd1);
      chk("b2b_capture", 32'(capture), 32'b0101);
      tick();
      chk("b2b_gap_done", 32'(done), 32'd0);
      chk("b2b_gap_busy", 32'(busy), 32'd0);
      chk("b2b_gap_valid", 32'(valid), 32'd1);
      tick();
    end
    start = 1'b0;
    repeat (6) tick();
    chk("final_idle", 32'(busy), 32'd0);
    chk("final_valid", 32'(valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
